serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller: time-shares one 1-bit full-adder cell (sum = a^b^c, carry = majority) over WIDTH clock cycles to add two WIDTH-bit operands LSB-first.
- Start/Busy/Done handshake; registered carry flip-flop; result register that holds until the next operation completes.
- Sits between a parallel operand source and any consumer that can tolerate WIDTH+1 cycles of latency in exchange for a single adder cell.

---
 rtl/serial_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder. A single 1-bit full-adder cell is reused over WIDTH
//   clock cycles to add two WIDTH-bit operands LSB-first. Start is sampled
//   only while idle. Busy is high for exactly WIDTH cycles. Done pulses for
//   one cycle when Sum/Cout are updated. Sum/Cout hold until the next
//   operation completes.
//
//   Optional build macro: SERIAL_ADDER_SUB_EN
//     Adds the Sub input. With Sub=1, B is inverted at load and the carry
//     is preset to 1, which gives Sum = A - B. In that case Cout=1 means
//     no borrow.
//
// Ports
//   Clk      in   rising-edge clock
//   Reset_n  in   asynchronous active-low reset
//   Start    in   operation request (ignored while Busy)
//   A, B     in   WIDTH-bit operands, captured on accepted Start
//   Cin      in   carry-in, captured on accepted Start
//   Sub      in   (SERIAL_ADDER_SUB_EN only) subtract select
//   Busy     out  serial add in progress
//   Done     out  one-cycle pulse on result update
//   Sum      out  registered WIDTH-bit result
//   Cout     out  registered final carry
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sha, r_shb, r_acc, r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_cout, r_done;

  logic             w_load, w_step, w_last;
  logic             w_s, w_c;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic [WIDTH-1:0] w_acc_nxt;

  // Shared full-adder cell operating on the current LSBs and the carry FF.
  assign w_s = r_sha[0] ^ r_shb[0] ^ r_carry;
  assign w_c = (r_sha[0] & r_shb[0]) | (r_sha[0] & r_carry) | (r_shb[0] & r_carry);

  // Sum bits enter at the MSB. After WIDTH shifts the first bit has reached bit 0.
  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: ~B plus a forced carry-in of 1.
  assign w_b_load = Sub ? ~B : B;
  assign w_c_load = Sub ? 1'b1 : Cin;
`else
  assign w_b_load = B;
  assign w_c_load = Cin;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sha   <= A;
        r_shb   <= w_b_load;
        r_carry <= w_c_load;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
        r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
        r_acc   <= w_acc_nxt;
        r_carry <= w_c;
        r_cnt   <= r_cnt + 1'b1;
      end
      // The result register is written only on the final bit. It holds
      // its value throughout RUN.
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_c;
      end
    end
  end

  assign Busy = (r_state == RUN);
  assign Done = r_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic [W-1:0] A, B;
  logic         Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         Sub;
`endif
  logic         Busy, Done, Cout;
  logic [W-1:0] Sum;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub    (Sub),
`endif
    .Busy   (Busy),
    .Done   (Done),
    .Sum    (Sum),
    .Cout   (Cout)
  );

  always #5 Clk = ~Clk;

  // Advance one edge; inputs and samples are settled 1 ns after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one operation and let the accepting edge happen.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    A = a; B = b; Cin = c; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Called just after the accepting edge. Counts Busy cycles and checks that
  // Sum/Cout hold the previous result. Optionally pokes an ignored Start at
  // busy cycle poke_at. Returns in the Done cycle.
  task automatic finish_op(input string tag, input logic [W-1:0] exp_sum, input logic exp_cout,
                           input logic [W-1:0] hold_sum, input logic hold_cout, input int poke_at);
    int n;
    bit hold_ok;
    n = 0;
    hold_ok = 1'b1;
    while (Busy && n < 40) begin
      if (Sum !== hold_sum || Cout !== hold_cout || Done !== 1'b0) hold_ok = 1'b0;
      n++;
      if (n == poke_at) begin
        Start = 1'b1; A = 8'h10;
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    Start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(W));
    check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    check({tag, "_done"}, 64'(Done), 64'd1);
    check({tag, "_sum"}, 64'(Sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(Cout), 64'(exp_cout));
  endtask

  initial begin
    bit clean;
    Reset_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    Sub = 1'b0;
`endif
    // Reset, then stay idle.
    clean = 1'b1;
    repeat (3) begin
      tick();
      if ({Busy, Done, Cout, Sum} !== '0) clean = 1'b0;
    end
    check("reset_outputs", 64'(clean), 64'd1);
    Reset_n = 1'b1;
    clean = 1'b1;
    repeat (20) begin
      tick();
      if ({Busy, Done, Cout, Sum} !== '0) clean = 1'b0;
    end
    check("idle_outputs", 64'(clean), 64'd1);

    // Basic add.
    start_op(8'h3C, 8'h45, 1'b0);
    finish_op("basic", 8'h81, 1'b0, 8'h00, 1'b0, 0);
    tick();
    check("basic_done_drop", 64'(Done), 64'd0);

    // Carry chain.
    start_op(8'hFF, 8'h00, 1'b1);
    finish_op("chain", 8'h00, 1'b1, 8'h81, 1'b0, 0);
    tick();

    // Max operands.
    start_op(8'hFF, 8'hFF, 1'b1);
    finish_op("max", 8'hFF, 1'b1, 8'h00, 1'b1, 0);
    tick();

    // Start during RUN is ignored. Back-to-back Start in the Done cycle is accepted.
    start_op(8'h01, 8'h01, 1'b0);
    finish_op("ignore", 8'h02, 1'b0, 8'hFF, 1'b1, 3);
    start_op(8'h80, 8'h80, 1'b0);
    check("b2b_busy", 64'(Busy), 64'd1);
    check("b2b_done_drop", 64'(Done), 64'd0);
    finish_op("b2b", 8'h00, 1'b1, 8'h02, 1'b0, 0);
    tick();

    // Reset in RUN cycle 4 aborts at once.
    start_op(8'h3C, 8'h45, 1'b0);
    repeat (3) tick();
    check("mid_busy_before", 64'(Busy), 64'd1);
    Reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_sum", 64'({Cout, Sum}), 64'd0);
    tick();
    Reset_n = 1'b1;
    clean = 1'b1;
    repeat (12) begin
      tick();
      if (Done !== 1'b0 || Busy !== 1'b0 || Sum !== 8'h00) clean = 1'b0;
    end
    check("abort_no_resume", 64'(clean), 64'd1);

`ifdef SERIAL_ADDER_SUB_EN
    Sub = 1'b1;
    start_op(8'h05, 8'h07, 1'b0);
    finish_op("sub_borrow", 8'hFE, 1'b0, 8'h00, 1'b0, 0);
    tick();
    start_op(8'h07, 8'h05, 1'b0);
    finish_op("sub_noborrow", 8'h02, 1'b1, 8'hFE, 1'b0, 0);
    tick();
    Sub = 1'b0;
    start_op(8'h07, 8'h05, 1'b0);
    finish_op("sub_off", 8'h0C, 1'b0, 8'h02, 1'b1, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Wall-clock guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
